imm_issue_queue: RTL and testbench

Instruction-decode issue queue sitting between fetch and the ID-stage consumers. It accepts instruction/PC pairs over a valid/ready handshake and selects the correct immediate format from the opcode. On enqueue it decodes the sign-extended immediate and the PC-relative target, so each queue entry holds them precomputed. Entries are presented in order over a second valid/ready handshake, with flush support for redirects.

---
 rtl/imm_issue_queue_if.sv | 28 ++
 rtl/imm_issue_queue.sv | 164 ++++++++++++++++
 tb/tb_imm_issue_queue.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/imm_issue_queue_if.sv
// Handshake bundle for the immediate-decoding issue queue.
// The upstream enqueue port and the downstream head port share this one bundle.
interface imm_issue_queue_if #(
    parameter int unsigned XLEN = 32
);
    logic            i_valid;
    logic            o_ready;
    logic [31:0]     i_instruction;
    logic [XLEN-1:0] i_pc;
    logic            i_flush;
    logic            o_valid;
    logic            i_ready;
    logic [31:0]     o_instruction;
    logic [XLEN-1:0] o_pc;
    logic [XLEN-1:0] o_immediate;
    logic [2:0]      o_imm_fmt;
    logic [XLEN-1:0] o_target;

    modport master (
        output i_valid, i_instruction, i_pc, i_flush, i_ready,
        input  o_ready, o_valid, o_instruction, o_pc, o_immediate, o_imm_fmt, o_target
    );

    modport slave (
        input  i_valid, i_instruction, i_pc, i_flush, i_ready,
        output o_ready, o_valid, o_instruction, o_pc, o_immediate, o_imm_fmt, o_target
    );
endinterface

// File: rtl/imm_issue_queue.sv
// In-order issue queue that decodes the RISC-V immediate and the PC-relative
// target on enqueue, so each entry holds them ready for the ID stage.
module imm_issue_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input logic              i_clk,
    input logic              i_rst,
    imm_issue_queue_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_NONE = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_e;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] tgt;
        fmt_e            fmt;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    occ_e              occ_q, occ_d;

    logic              enq;
    logic              deq;
    logic [31:0]       inst;
    logic signed [31:0] imm32;
    fmt_e              fmt;
    logic              pc_rel;
    entry_t            new_entry;
    entry_t            head;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        inst   = bus.i_instruction;
        fmt    = FMT_NONE;
        imm32  = '0;
        pc_rel = 1'b0;
        case (inst[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                fmt   = FMT_I;
                imm32 = {{20{inst[31]}}, inst[31:20]};
            end
            7'b0100011: begin
                fmt   = FMT_S;
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            7'b1100011: begin
                fmt    = FMT_B;
                imm32  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                pc_rel = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                fmt    = FMT_U;
                imm32  = {inst[31:12], 12'h000};
                pc_rel = (inst[6:0] == 7'b0010111);
            end
            7'b1101111: begin
                fmt    = FMT_J;
                imm32  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                pc_rel = 1'b1;
            end
            default: ;
        endcase
        new_entry.instr = inst;
        new_entry.pc    = bus.i_pc;
        new_entry.imm   = XLEN'($signed(imm32));
        new_entry.tgt   = pc_rel ? bus.i_pc + XLEN'($signed(imm32)) : '0;
        new_entry.fmt   = fmt;
    end

    always_comb begin
        enq      = bus.i_valid && (occ_q != OCC_FULL) && !bus.i_flush;
        deq      = (occ_q != OCC_EMPTY) && bus.i_ready && !bus.i_flush;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (deq) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: ;
        endcase
        if (bus.i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        // Occupancy is registered so o_ready never depends on i_ready combinationally.
        if (count_d == '0) begin
            occ_d = OCC_EMPTY;
        end else if (count_d == CNT_W'(DEPTH)) begin
            occ_d = OCC_FULL;
        end else begin
            occ_d = OCC_PARTIAL;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            occ_q    <= OCC_EMPTY;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        head              = mem_q[rd_ptr_q];
        bus.o_valid       = (occ_q != OCC_EMPTY);
        bus.o_ready       = (occ_q != OCC_FULL);
        bus.o_instruction = '0;
        bus.o_pc          = '0;
        bus.o_immediate   = '0;
        bus.o_imm_fmt     = FMT_NONE;
        bus.o_target      = '0;
        if (bus.o_valid) begin
            bus.o_instruction = head.instr;
            bus.o_pc          = head.pc;
            bus.o_immediate   = head.imm;
            bus.o_imm_fmt     = head.fmt;
            bus.o_target      = head.tgt;
        end
    end
endmodule

// File: tb/tb_imm_issue_queue.sv
// Scoreboard bench for imm_issue_queue: directed cases followed by random traffic
// checked against a queue-based reference model.
module tb_imm_issue_queue;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    imm_issue_queue_if #(.XLEN(XLEN)) bus ();

    imm_issue_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] tgt;
        logic [31:0] fmt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   occ;

    function automatic logic [31:0] sext(input longint v, input int bits);
        longint m;
        m = v & ((64'sd1 <<< bits) - 1);
        if (m >= (64'sd1 <<< (bits - 1))) m = m - (64'sd1 <<< bits);
        return 32'(m);
    endfunction

    // Reference decode built from the ISA field definitions with plain arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t   e;
        longint x;
        int     opc;
        bit     rel;
        x   = longint'(ins);
        opc = int'(x & 127);
        rel = 1'b0;
        e.instr = ins;
        e.pc    = pc;
        e.imm   = 32'd0;
        e.fmt   = 32'd7;
        if (opc == 'h03 || opc == 'h13 || opc == 'h67) begin
            e.fmt = 0; e.imm = sext(x >> 20, 12);
        end else if (opc == 'h23) begin
            e.fmt = 1; e.imm = sext((((x >> 25) & 127) << 5) | ((x >> 7) & 31), 12);
        end else if (opc == 'h63) begin
            e.fmt = 2; rel = 1'b1;
            e.imm = sext((((x >> 31) & 1) << 12) | (((x >> 7) & 1) << 11)
                       | (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1), 13);
        end else if (opc == 'h37 || opc == 'h17) begin
            e.fmt = 3; e.imm = 32'(x & 'hFFFFF000); rel = (opc == 'h17);
        end else if (opc == 'h6F) begin
            e.fmt = 4; rel = 1'b1;
            e.imm = sext((((x >> 31) & 1) << 20) | (((x >> 12) & 255) << 12)
                       | (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1), 21);
        end
        e.tgt = rel ? pc + e.imm : 32'd0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the scoreboard push/clear mirrors the handshake rules.
    task automatic cycle(input bit rst, input bit v, input logic [31:0] ins,
                         input logic [31:0] pc, input bit rdy, input bit fl);
        i_rst             = rst;
        bus.i_valid       = v;
        bus.i_instruction = ins;
        bus.i_pc          = pc;
        bus.i_ready       = rdy;
        bus.i_flush       = fl;
        occ               = sb.size();
        @(posedge i_clk);
        if (rst || fl) sb.delete();
        else if (v && occ != DEPTH) sb.push_back(ref_decode(ins, pc));
        #1;
        mon_en = 1'b1;
    endtask

    task automatic head_lit(input string name, input logic [2:0] fmt,
                            input logic [31:0] imm, input logic [31:0] tgt);
        chk({name, "_valid"}, 32'(bus.o_valid), 32'd1);
        chk({name, "_fmt"}, 32'(bus.o_imm_fmt), 32'(fmt));
        chk({name, "_imm"}, bus.o_immediate, imm);
        chk({name, "_tgt"}, bus.o_target, tgt);
    endtask

    initial begin : monitor
        forever begin
            @(negedge i_clk);
            if (mon_en) begin
                chk("o_valid", 32'(bus.o_valid), 32'(sb.size() != 0));
                chk("o_ready", 32'(bus.o_ready), 32'(sb.size() != DEPTH));
                if (sb.size() != 0) begin
                    chk("head_instr", bus.o_instruction, sb[0].instr);
                    chk("head_pc", bus.o_pc, sb[0].pc);
                    chk("head_imm", bus.o_immediate, sb[0].imm);
                    chk("head_fmt", 32'(bus.o_imm_fmt), sb[0].fmt);
                    chk("head_tgt", bus.o_target, sb[0].tgt);
                    if (bus.i_ready && !bus.i_flush && !i_rst) void'(sb.pop_front());
                end else begin
                    chk("idle_instr", bus.o_instruction, 32'd0);
                    chk("idle_pc", bus.o_pc, 32'd0);
                    chk("idle_imm", bus.o_immediate, 32'd0);
                    chk("idle_fmt", 32'(bus.o_imm_fmt), 32'd7);
                    chk("idle_tgt", bus.o_target, 32'd0);
                end
            end
        end
    end

    logic [6:0] opc_tab [10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

    initial begin : driver
        logic [31:0] r;
        logic [6:0]  opc;
        bit          v, rdy, fl, rst;
        int          rdy_pct;

        cycle(1, 1, 32'h00100093, 32'h0, 1, 0);
        cycle(1, 0, 32'h0, 32'h0, 0, 0);
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_ready", 32'(bus.o_ready), 32'd1);
        chk("rst_fmt", 32'(bus.o_imm_fmt), 32'd7);

        cycle(0, 1, 32'hFE000EE3, 32'h100, 0, 0);
        head_lit("beq", 3'd2, 32'hFFFFFFFC, 32'h000000FC);
        cycle(0, 0, 32'h0, 32'h0, 1, 0);

        cycle(0, 1, 32'h0080006F, 32'h200, 1, 0);
        head_lit("jal", 3'd4, 32'h8, 32'h208);
        cycle(0, 1, 32'h12345037, 32'h204, 1, 0);
        head_lit("lui", 3'd3, 32'h12345000, 32'h0);
        cycle(0, 0, 32'h0, 32'h0, 1, 0);

        cycle(0, 1, 32'h00100093, 32'h10, 0, 0);
        cycle(0, 1, 32'h00200093, 32'h14, 0, 0);
        chk("full_ready", 32'(bus.o_ready), 32'd0);
        cycle(0, 1, 32'h00300093, 32'h18, 0, 0);
        chk("full_hold_ready", 32'(bus.o_ready), 32'd0);
        chk("full_hold_pc", bus.o_pc, 32'h10);
        cycle(0, 0, 32'h0, 32'h0, 1, 0);
        chk("drain1_pc", bus.o_pc, 32'h14);
        chk("drain1_ready", 32'(bus.o_ready), 32'd1);
        cycle(0, 0, 32'h0, 32'h0, 1, 0);
        chk("drain2_valid", 32'(bus.o_valid), 32'd0);

        cycle(0, 1, 32'h00000013, 32'h300, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 1, 32'h00000013, 32'h300 + 32'(4 * i), 1, 0);
            chk("simul_pc", bus.o_pc, 32'h300 + 32'(4 * i));
            chk("simul_ready", 32'(bus.o_ready), 32'd1);
        end
        cycle(0, 0, 32'h0, 32'h0, 1, 0);

        cycle(0, 1, 32'h00000013, 32'h400, 0, 0);
        cycle(0, 1, 32'h00000013, 32'h404, 0, 0);
        cycle(0, 1, 32'h00000013, 32'h408, 1, 1);
        chk("flush_valid", 32'(bus.o_valid), 32'd0);
        chk("flush_ready", 32'(bus.o_ready), 32'd1);
        cycle(0, 0, 32'h0, 32'h0, 0, 0);
        chk("flush_empty", 32'(bus.o_valid), 32'd0);

        cycle(0, 1, 32'h0000007F, 32'h500, 0, 0);
        head_lit("none", 3'd7, 32'h0, 32'h0);
        cycle(0, 1, 32'hFFFFF017, 32'h800, 1, 0);
        head_lit("auipc", 3'd3, 32'hFFFFF000, 32'hFFFFF800);
        cycle(0, 0, 32'h0, 32'h0, 1, 0);

        rdy_pct = 70;
        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 0) rdy_pct = 15 + 30 * ((n / 500) % 3);
            r   = $urandom();
            opc = opc_tab[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) opc = r[6:0];
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 99) < rdy_pct);
            fl  = ($urandom_range(0, 31) == 0);
            rst = (n == 1700);
            cycle(rst, v, {r[31:7], opc}, $urandom(), rdy, fl);
        end
        for (int k = 0; k < 4; k++) cycle(0, 0, 32'h0, 32'h0, 1, 0);
        @(negedge i_clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
